// File: rtl/img_pkg.sv
// Shared constants and state encoding for the camera downsampler.
package img_pkg;

    localparam int unsigned PIX_W   = 12;   // camera pixel width
    localparam int unsigned OUT_W   = 16;   // output pixel width
    localparam int unsigned BLK_SZ  = 16;   // block edge in pixels
    localparam int unsigned BLK_LG  = 4;    // log2(BLK_SZ)
    localparam int unsigned CROP_SZ = 448;  // crop window edge at default output size
    localparam int unsigned ACC_W   = 20;   // 256 x 12-bit sum never overflows
    localparam int unsigned OUT_PIX = 784;  // outputs per frame at default output size

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/img_downsample_blk_accum.sv
// One running sum per output column; the last pixel of a block reads out and clears its sum.
module blk_accum
    import img_pkg::*;
#(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              clr_all_i,
    input  logic              add_i,
    input  logic              clr_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [ACC_W-1:0]  sum_o_c
);

    logic [ACC_W-1:0] acc_q [DEPTH];

    // Block sum including the pixel currently presented
    assign sum_o_c = acc_q[idx_i] + ACC_W'(pix_i);

    // Accumulate, or zero the entry when the block completes, or wipe everything on abort
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) acc_q[i] <= '0;
        end else if (clr_all_i) begin
            for (int i = 0; i < int'(DEPTH); i++) acc_q[i] <= '0;
        end else if (add_i) begin
            acc_q[idx_i] <= clr_i ? '0 : sum_o_c;
        end
    end

endmodule

// File: rtl/img_downsample.sv
// Crops a camera frame and emits the 16x16 block means in raster order.
module img_downsample
    import img_pkg::*;
#(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned CROP_X0 = 96,
    parameter int unsigned CROP_Y0 = 16,
    parameter int unsigned OUT_DIM = 28
) (
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              iEN,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [PIX_W-1:0]  iDATA,
    output logic              oFVAL,
    output logic              oDVAL,
    output logic [OUT_W-1:0]  oDATA,
    output logic              oFrame_done,
    output logic              oErr_short
);

    localparam int unsigned WIN   = OUT_DIM * BLK_SZ;
    localparam int unsigned N_OUT = (WIN == CROP_SZ) ? OUT_PIX : OUT_DIM * OUT_DIM;
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H + 1);
    localparam int unsigned IW    = $clog2(OUT_DIM);
    localparam int unsigned OCW   = $clog2(N_OUT + 1);

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [OCW-1:0]   ocnt_q, ocnt_d;
    logic             prev_q;
    logic             fval_q;
    logic             dval_q, dval_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             in_win_c;
    logic             blk_end_c;
    logic [IW-1:0]    bx_c;
    logic             acc_add_c, acc_clr_c, acc_clr_all_c;
    logic [ACC_W-1:0] sum_c;

    // Window membership and block position of the current pixel
    always_comb begin
        in_win_c  = (32'(x_q) >= CROP_X0) && (32'(x_q) < CROP_X0 + WIN) &&
                    (32'(y_q) >= CROP_Y0) && (32'(y_q) < CROP_Y0 + WIN);
        blk_end_c = (4'(x_q - XW'(CROP_X0)) == 4'hF) && (4'(y_q - YW'(CROP_Y0)) == 4'hF);
        bx_c      = IW'((x_q - XW'(CROP_X0)) >> BLK_LG);
    end

    blk_accum #(
        .DEPTH (OUT_DIM),
        .IW    (IW)
    ) u_blk_accum (
        .pxlclk    (pxlclk),
        .rst_n     (rst_n),
        .clr_all_i (acc_clr_all_c),
        .add_i     (acc_add_c),
        .clr_i     (acc_clr_c),
        .idx_i     (bx_c),
        .pix_i     (iDATA),
        .sum_o_c   (sum_c)
    );

    // Frame sequencing, raster counters and output generation
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        ocnt_d        = ocnt_q;
        dval_d        = 1'b0;
        data_d        = data_q;
        last_d        = 1'b0;
        done_d        = last_q;
        err_d         = 1'b0;
        acc_add_c     = 1'b0;
        acc_clr_c     = 1'b0;
        acc_clr_all_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iFVAL && !prev_q && iEN) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    ocnt_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (!iFVAL) begin
                    err_d         = 1'b1;
                    state_d       = ST_IDLE;
                    x_d           = '0;
                    y_d           = '0;
                    ocnt_d        = '0;
                    acc_clr_all_c = 1'b1;
                end else if (iDVAL) begin
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (in_win_c) begin
                        acc_add_c = 1'b1;
                        if (blk_end_c) begin
                            acc_clr_c = 1'b1;
                            dval_d    = 1'b1;
                            data_d    = OUT_W'(sum_c >> 8);
                            ocnt_d    = ocnt_q + OCW'(1);
                            if (ocnt_q == OCW'(N_OUT - 1)) begin
                                last_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; prev_q resets high so a frame already in flight at release is skipped
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ocnt_q  <= '0;
            prev_q  <= 1'b1;
            fval_q  <= 1'b0;
            dval_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ocnt_q  <= ocnt_d;
            prev_q  <= iFVAL;
            fval_q  <= iFVAL;
            dval_q  <= dval_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oFVAL       = fval_q;
    assign oDVAL       = dval_q;
    assign oDATA       = data_q;
    assign oFrame_done = done_q;
    assign oErr_short  = err_q;

endmodule

// File: tb/tb_img_downsample.sv
// Directed frames against a scaled-down image; expectations are hand-derived block means.
module tb_img_downsample;

    localparam int W    = 80;
    localparam int H    = 72;
    localparam int CX   = 8;
    localparam int CY   = 4;
    localparam int OD   = 4;
    localparam int WIN  = OD * 16;
    localparam int NOUT = OD * OD;

    logic        pxlclk;
    logic        rst_n;
    logic        iEN, iFVAL, iDVAL;
    logic [11:0] iDATA;
    logic        oFVAL, oDVAL, oFrame_done, oErr_short;
    logic [15:0] oDATA;

    img_downsample #(
        .IMG_W   (W),
        .IMG_H   (H),
        .CROP_X0 (CX),
        .CROP_Y0 (CY),
        .OUT_DIM (OD)
    ) dut (
        .pxlclk      (pxlclk),
        .rst_n       (rst_n),
        .iEN         (iEN),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .iDATA       (iDATA),
        .oFVAL       (oFVAL),
        .oDVAL       (oDVAL),
        .oDATA       (oDATA),
        .oFrame_done (oFrame_done),
        .oErr_short  (oErr_short)
    );

    initial pxlclk = 1'b0;
    always #5 pxlclk = ~pxlclk;

    int n_total = 0;
    int n_bad   = 0;
    int n_dval, n_done, n_err;

    bit        pend_dval, pend_last, pend_err;
    bit [15:0] pend_data;
    bit        exp_dval_d, exp_last_d, exp_done_d, exp_err_d;
    bit [15:0] exp_data_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Input pixel per test pattern
    function automatic logic [11:0] pix(input int mode, input int x, input int y, input bit inw);
        case (mode)
            0:       return 12'hFFF;
            1:       return 12'(x);
            2:       return inw ? 12'h000 : 12'hFFF;
            default: return 12'(y);
        endcase
    endfunction

    // Block mean: constant -> FFF, x ramp -> first column + 7, crop pattern -> 0, y ramp -> first line + 7
    function automatic logic [15:0] exp_blk(input int mode, input int bx, input int by);
        case (mode)
            0:       return 16'h0FFF;
            1:       return 16'(CX + 16 * bx + 7);
            2:       return 16'h0000;
            default: return 16'(CY + 16 * by + 7);
        endcase
    endfunction

    // Expected-event pipeline aligned to the DUT's registered outputs
    always @(posedge pxlclk) begin
        exp_dval_d <= pend_dval;
        exp_data_d <= pend_data;
        exp_last_d <= pend_last;
        exp_done_d <= exp_last_d;
        exp_err_d  <= pend_err;
    end

    // Output monitor
    always @(negedge pxlclk) begin
        if (oDVAL === 1'b1) n_dval++;
        if (oFrame_done === 1'b1) n_done++;
        if (oErr_short === 1'b1) n_err++;
        if (oDVAL || exp_dval_d) begin
            chk("dval", 32'(oDVAL), 32'(exp_dval_d));
            if (exp_dval_d) chk("data", 32'(oDATA), 32'(exp_data_d));
        end
        if (oFrame_done || exp_done_d) chk("frame_done", 32'(oFrame_done), 32'(exp_done_d));
        if (oErr_short || exp_err_d) chk("err_short", 32'(oErr_short), 32'(exp_err_d));
    end

    task automatic step();
        @(posedge pxlclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fval"}, 32'(oFVAL), 32'd0);
        chk({tag, "_dval"}, 32'(oDVAL), 32'd0);
        chk({tag, "_data"}, 32'(oDATA), 32'd0);
        chk({tag, "_done"}, 32'(oFrame_done), 32'd0);
        chk({tag, "_err"}, 32'(oErr_short), 32'd0);
    endtask

    // One camera frame; drop_line/rst_line < 0 disables that event
    task automatic run_frame(input int mode, input bit en, input bit en_toggle,
                             input int drop_line, input int rst_line);
        bit cap;
        bit inw;
        int exp_n;
        int exp_done;
        int exp_err;
        cap      = en;
        exp_n    = 0;
        exp_done = 0;
        exp_err  = 0;
        n_dval   = 0;
        n_done   = 0;
        n_err    = 0;
        iEN      = en;
        iFVAL    = 1'b0;
        iDVAL    = 1'b0;
        step();
        chk("fval_low", 32'(oFVAL), 32'd0);
        iFVAL = 1'b1;
        step();
        chk("fval_high", 32'(oFVAL), 32'd1);
        step();
        if (en_toggle) iEN = 1'b0;
        for (int y = 0; y < H; y++) begin
            if (y == drop_line) break;
            if (y == rst_line) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                repeat (3) step();
                rst_n = 1'b1;
                cap   = 1'b0;
            end
            for (int x = 0; x < W; x++) begin
                inw       = (x >= CX) && (x < CX + WIN) && (y >= CY) && (y < CY + WIN);
                iDVAL     = 1'b1;
                iDATA     = pix(mode, x, y, inw);
                pend_dval = 1'b0;
                pend_last = 1'b0;
                if (cap && inw && ((x - CX) % 16 == 15) && ((y - CY) % 16 == 15)) begin
                    pend_dval = 1'b1;
                    pend_data = exp_blk(mode, (x - CX) / 16, (y - CY) / 16);
                    exp_n++;
                    if (exp_n == NOUT) begin
                        pend_last = 1'b1;
                        cap       = 1'b0;
                        exp_done  = 1;
                    end
                end
                step();
            end
            iDVAL     = 1'b0;
            pend_dval = 1'b0;
            pend_last = 1'b0;
            repeat (4) step();
        end
        iFVAL     = 1'b0;
        iDVAL     = 1'b0;
        pend_dval = 1'b0;
        pend_last = 1'b0;
        if (cap) begin
            pend_err = 1'b1;
            exp_err  = 1;
        end
        step();
        pend_err = 1'b0;
        repeat (8) step();
        iEN = 1'b1;
        chk("n_dval", 32'(n_dval), 32'(exp_n));
        chk("n_done", 32'(n_done), 32'(exp_done));
        chk("n_err", 32'(n_err), 32'(exp_err));
    endtask

    initial begin
        rst_n     = 1'b0;
        iEN       = 1'b0;
        iFVAL     = 1'b0;
        iDVAL     = 1'b0;
        iDATA     = 12'h000;
        pend_dval = 1'b0;
        pend_last = 1'b0;
        pend_err  = 1'b0;
        pend_data = 16'h0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) step();

        run_frame(0, 1'b1, 1'b0, -1, -1);   // constant full scale
        run_frame(1, 1'b1, 1'b0, -1, -1);   // horizontal ramp
        run_frame(2, 1'b1, 1'b0, -1, -1);   // bright border, dark window
        run_frame(3, 1'b1, 1'b1, -1, -1);   // vertical ramp, enable dropped mid-frame
        run_frame(1, 1'b1, 1'b0, 30, -1);   // frame cut short mid block row
        run_frame(0, 1'b1, 1'b0, -1, -1);   // recovery after short frame
        run_frame(0, 1'b0, 1'b0, -1, -1);   // capture disabled at frame start
        run_frame(0, 1'b1, 1'b0, -1, 40);   // reset mid-frame
        run_frame(0, 1'b1, 1'b0, -1, -1);   // recovery after reset

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/img_downsample.md
IMG_DOWNSAMPLE -- requirements
Module: img_downsample

Interface
REQ-001 Parameter IMG_W, default 640: valid pixels per input line.
REQ-002 Parameter IMG_H, default 480: lines per input frame.
REQ-003 Parameter CROP_X0, default 96: first cropped column.
REQ-004 Parameter CROP_Y0, default 16: first cropped line.
REQ-005 Parameter OUT_DIM, default 28: output image is OUT_DIM x OUT_DIM; block size fixed at 16 (crop window 448x448).
REQ-006 pxlclk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 iEN  in  1  capture enable; sampled only at frame start.
REQ-009 iFVAL  in  1  camera frame valid.
REQ-010 iDVAL  in  1  camera pixel valid, one pixel per asserted cycle.
REQ-011 iDATA  in  12  grayscale pixel, unsigned.
REQ-012 oFVAL  out  1  frame valid, iFVAL delayed one cycle.
REQ-013 oDVAL  out  1  downsampled pixel valid, single-cycle pulse.
REQ-014 oDATA  out  16  downsampled pixel, raster order.
REQ-015 oFrame_done  out  1  one-cycle pulse after pixel 783 emitted.
REQ-016 oErr_short  out  1  one-cycle pulse when iFVAL falls before frame completes.

Function
REQ-017 States IDLE, ACTIVE; IDLE->ACTIVE on iFVAL rising edge (iFVAL high, prior-cycle iFVAL low) with iEN=1; otherwise remain IDLE.
REQ-018 In ACTIVE, x counter increments per iDVAL, wraps at IMG_W-1 to 0 and increments y counter; counters zero on IDLE->ACTIVE.
REQ-019 Pixel in crop window (CROP_X0 <= x < CROP_X0+448, CROP_Y0 <= y < CROP_Y0+448) added into accumulator bx=(x-CROP_X0)>>4; pixels outside window ignored.
REQ-020 Accumulators: OUT_DIM entries, 20 bits each (256 x 12-bit, no overflow possible).
REQ-021 Pixel with (x-CROP_X0)[3:0]=15 and (y-CROP_Y0)[3:0]=15: next cycle oDVAL=1, oDATA={4'b0, (acc[bx]+iDATA)[19:8]}; acc[bx] cleared same edge.
REQ-022 Output latency: exactly one pxlclk from completing input pixel to oDVAL.
REQ-023 Output counter counts oDVAL pulses; on 784th, oFrame_done pulses the cycle after oDVAL and state -> IDLE.
REQ-024 oDVAL never asserted while oFVAL low; oDVAL only in ACTIVE.
REQ-025 iFVAL low in ACTIVE before 784 outputs: oErr_short pulses next cycle, accumulators and counters cleared, state -> IDLE; no further oDVAL that frame.
REQ-026 iDVAL ignored while iFVAL low and in IDLE.
REQ-027 iEN deasserted mid-frame has no effect; current frame completes.
REQ-028 Frame start while ACTIVE impossible without prior FVAL fall; REQ-025 governs.

Reset
REQ-029 On rst_n low: state IDLE, counters 0, accumulators 0, oFVAL/oDVAL/oFrame_done/oErr_short 0, oDATA 16'h0.
REQ-030 Reset mid-frame discards the frame; after release, capture resumes only on next iFVAL rising edge.

Structure
REQ-031 Package img_pkg holds state typedef, block size 16, crop size 448, accumulator width 20, output pixel count 784.
REQ-032 One sub-module blk_accum: OUT_DIM x 20-bit register array with add-and-clear port, instantiated once.

Verification
REQ-033 Constant frame iDATA=12'hFFF, iEN=1 -> 784 oDVAL pulses, all oDATA=16'h0FFF, oFrame_done once, one cycle after 784th.
REQ-034 Ramp frame iDATA=x[11:0] -> row 0 output k oDATA = 96+16k+7 (integer floor of block mean); 28 per block row.
REQ-035 Outside-crop pixels 12'hFFF, inside 12'h000 -> all 784 outputs 16'h0000.
REQ-036 iFVAL dropped at line 200 -> oErr_short one pulse, no oFrame_done, next full frame yields 784 correct outputs.
REQ-037 iEN=0 at frame start -> zero oDVAL for that frame; iEN toggled low mid-frame -> frame still completes with 784 outputs.
REQ-038 rst_n pulsed at line 300 -> outputs zero immediately; next frame yields 784 outputs matching constant-frame reference.
